// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue bundle between dispatch logic, the ALU reservation station and the ALU.
// master = surrounding pipeline (drives dispatch/CDB/alu_ready), slave = reservation station.
interface alu_reservation_station_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             disp_valid;
    logic             disp_ready;
    logic [2:0]       disp_alu_ext;
    logic [2:0]       disp_funct3;
    logic [TAG_W-1:0] disp_rd_tag;
    logic [XLEN-1:0]  disp_src1_val;
    logic [TAG_W-1:0] disp_src1_tag;
    logic             disp_src1_rdy;
    logic [XLEN-1:0]  disp_src2_val;
    logic [TAG_W-1:0] disp_src2_tag;
    logic             disp_src2_rdy;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;

    logic             alu_ready;
    logic [XLEN-1:0]  iss_op1;
    logic [XLEN-1:0]  iss_op2;
    logic [2:0]       iss_alu_ext;
    logic [2:0]       iss_funct3;
    logic [TAG_W-1:0] iss_tag;
    logic             iss_tag_valid;

    modport master (
        output disp_valid, disp_alu_ext, disp_funct3, disp_rd_tag,
               disp_src1_val, disp_src1_tag, disp_src1_rdy,
               disp_src2_val, disp_src2_tag, disp_src2_rdy,
               cdb_valid, cdb_tag, cdb_data, alu_ready,
        input  disp_ready, iss_op1, iss_op2, iss_alu_ext, iss_funct3, iss_tag, iss_tag_valid
    );

    modport slave (
        input  disp_valid, disp_alu_ext, disp_funct3, disp_rd_tag,
               disp_src1_val, disp_src1_tag, disp_src1_rdy,
               disp_src2_val, disp_src2_tag, disp_src2_rdy,
               cdb_valid, cdb_tag, cdb_data, alu_ready,
        output disp_ready, iss_op1, iss_op2, iss_alu_ext, iss_funct3, iss_tag, iss_tag_valid
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU/branch/jump ops, wakes them from the CDB and
// issues the lowest-index ready op to the ALU through registered outputs.
module alu_reservation_station #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    alu_reservation_station_if.slave     rs,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] rdy1;
    logic [DEPTH-1:0] rdy2;
    logic [2:0]       ext_q  [DEPTH];
    logic [2:0]       f3_q   [DEPTH];
    logic [TAG_W-1:0] rd_q   [DEPTH];
    logic [TAG_W-1:0] tag1_q [DEPTH];
    logic [TAG_W-1:0] tag2_q [DEPTH];
    logic [XLEN-1:0]  val1_q [DEPTH];
    logic [XLEN-1:0]  val2_q [DEPTH];

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] wake1;
    logic [DEPTH-1:0] wake2;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] free_idx;
    logic             issue_en;
    logic             disp_en;
    logic             byp1_hit;
    logic             byp2_hit;

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(busy[i]);
        end
    end

    // Occupancy comes from registered busy bits only, so a slot freed by this cycle's issue is not reusable until next cycle.
    assign rs.disp_ready = (count != CNT_W'(DEPTH));
    assign eligible      = busy & rdy1 & rdy2;
    assign issue_en      = rs.alu_ready & (|eligible) & ~flush;
    assign disp_en       = rs.disp_valid & rs.disp_ready & ~flush;
    assign byp1_hit      = rs.cdb_valid & ~rs.disp_src1_rdy & (rs.cdb_tag == rs.disp_src1_tag);
    assign byp2_hit      = rs.cdb_valid & ~rs.disp_src2_rdy & (rs.cdb_tag == rs.disp_src2_tag);

    always_comb begin
        issue_idx = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) issue_idx = IDX_W'(i);
            if (!busy[i])    free_idx  = IDX_W'(i);
        end
    end

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = busy[i] & ~rdy1[i] & rs.cdb_valid & (tag1_q[i] == rs.cdb_tag);
            wake2[i] = busy[i] & ~rdy2[i] & rs.cdb_valid & (tag2_q[i] == rs.cdb_tag);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            rdy1 <= '0;
            rdy2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ext_q[i]  <= '0;
                f3_q[i]   <= '0;
                rd_q[i]   <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
            end
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i]) begin
                    val1_q[i] <= rs.cdb_data;
                    rdy1[i]   <= 1'b1;
                end
                if (wake2[i]) begin
                    val2_q[i] <= rs.cdb_data;
                    rdy2[i]   <= 1'b1;
                end
                if (issue_en && (issue_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b0;
                end
                // The free slot is never busy, so this write cannot collide with wakeup or issue above.
                if (disp_en && (free_idx == IDX_W'(i))) begin
                    busy[i]   <= 1'b1;
                    ext_q[i]  <= rs.disp_alu_ext;
                    f3_q[i]   <= rs.disp_funct3;
                    rd_q[i]   <= rs.disp_rd_tag;
                    tag1_q[i] <= rs.disp_src1_tag;
                    tag2_q[i] <= rs.disp_src2_tag;
                    val1_q[i] <= byp1_hit ? rs.cdb_data : rs.disp_src1_val;
                    val2_q[i] <= byp2_hit ? rs.cdb_data : rs.disp_src2_val;
                    rdy1[i]   <= rs.disp_src1_rdy | byp1_hit;
                    rdy2[i]   <= rs.disp_src2_rdy | byp2_hit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs.iss_op1       <= '0;
            rs.iss_op2       <= '0;
            rs.iss_alu_ext   <= '0;
            rs.iss_funct3    <= '0;
            rs.iss_tag       <= '0;
            rs.iss_tag_valid <= 1'b0;
        end else begin
            rs.iss_tag_valid <= issue_en;
            if (issue_en) begin
                rs.iss_op1     <= val1_q[issue_idx];
                rs.iss_op2     <= val2_q[issue_idx];
                rs.iss_alu_ext <= ext_q[issue_idx];
                rs.iss_funct3  <= f3_q[issue_idx];
                rs.iss_tag     <= rd_q[issue_idx];
            end
        end
    end
endmodule
